// File: rtl/ebab_arbiter.sv
// rtl/ebab_arbiter.sv - round-robin arbiter sharing one EBAB bridge port among several masters
module ebab_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data,
  input  logic [NUM_MASTERS-1:0]            m_read_en,
  input  logic [NUM_MASTERS-1:0]            m_write_en,
  input  logic [NUM_MASTERS-1:0]            m_byte_en,
  output logic [DATA_WIDTH-1:0]             m_read_data,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic                              m_err,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_write_data,
  output logic                              s_read_en,
  output logic                              s_write_en,
  output logic                              s_byte_en,
  input  logic [DATA_WIDTH-1:0]             s_read_data,
  input  logic                              s_ack
);

  localparam int          GW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last;
  logic [15:0]     r_wdog;

  logic [NUM_MASTERS-1:0] w_req;
  logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_MASTERS];
  logic                   w_found;
  logic [GW-1:0]          w_next_grant;
  logic [GW-1:0]          w_cand;
  logic                   w_busy;
  logic                   w_timeout;
  logic                   w_done;

  assign w_req = m_read_en | m_write_en;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
    assign w_addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = m_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_timeout = w_busy & ~s_ack & (r_wdog == WDOG_LAST);
  assign w_done    = w_busy & (s_ack | w_timeout);

  // Round-robin search: first requester starting just after the last served master
  always_comb begin
    w_found      = 1'b0;
    w_next_grant = '0;
    w_cand       = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = GW'((int'(r_last) + i) % NUM_MASTERS);
      if (!w_found && w_req[w_cand]) begin
        w_found      = 1'b1;
        w_next_grant = w_cand;
      end
    end
  end

  // Forward the granted master to the bridge and route completion back to it
  always_comb begin
    s_addr       = '0;
    s_write_data = '0;
    s_byte_en    = 1'b0;
    s_read_en    = 1'b0;
    s_write_en   = 1'b0;
    m_ack        = '0;
    m_err        = 1'b0;
    m_read_data  = '0;
    if (w_busy) begin
      s_addr       = w_addr_arr[r_grant];
      s_write_data = w_wdata_arr[r_grant];
      s_byte_en    = m_byte_en[r_grant];
      // Simultaneous read+write is treated as a write; a timed-out access is withdrawn
      s_write_en   = m_write_en[r_grant] & ~w_timeout;
      s_read_en    = m_read_en[r_grant] & ~m_write_en[r_grant] & ~w_timeout;
    end
    if (w_done) begin
      m_ack       = NUM_MASTERS'(1) << r_grant;
      m_err       = w_timeout;
      m_read_data = s_ack ? s_read_data : '1;
    end
  end

  // Grant FSM with watchdog; one IDLE cycle separates consecutive transactions
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_next_grant;
            r_wdog  <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end else if (r_wdog != 16'hFFFF) begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
